// File: rtl/spi_reg_host.sv
// SPI mode-0 register initiator: turns a one-cycle start strobe into a CS-framed
// rw/width/addr header followed by write data, or by turnaround cycles and read data.
module spi_reg_host #(
  parameter int ADDR_W    = 6,
  parameter int REG_W     = 32,
  parameter int CLK_DIV   = 4,
  parameter int TURN_BITS = 8,
  parameter int CS_GAP    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        txn_width,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [2:0]        dbg_state
);

  // Command handshake: start is taken only while busy is low (IDLE). rw, txn_width,
  // addr and wdata are captured on that same edge and busy rises the next cycle.
  // There is no backpressure and no queue: a start seen while busy is dropped.

  localparam int HDR_BITS = 3 + ADDR_W;
  localparam int TX_W     = 2 + ADDR_W + REG_W;
  localparam int CNT_W    = $clog2(HDR_BITS + TURN_BITS + REG_W + 1);
  localparam int GAP_W    = $clog2(CS_GAP + 1);

  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HDR_END  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] TURN_END = CNT_W'(HDR_BITS + TURN_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HDR   = 3'd2,
    S_TURN  = 3'd3,
    S_WDATA = 3'd4,
    S_RDATA = 3'd5,
    S_HOLD  = 3'd6,
    S_GAP   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TX_W-1:0]    tx_q, tx_d;
  logic [REG_W-1:0]   rx_q, rx_d;
  logic               rw_q, rw_d;
  logic [1:0]         width_q, width_d;
  logic               cs_n_q, cs_n_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic [REG_W-1:0]   rdata_q, rdata_d;
  logic               miso_m_q, miso_s_q;

  logic [CNT_W-1:0]   n_bits;
  logic [CNT_W-1:0]   seg_end;
  logic               div_wrap;
  state_t             seg_next;

  function automatic logic [CNT_W-1:0] width_bits(input logic [1:0] w);
    case (w)
      2'b00:   width_bits = CNT_W'(8);
      2'b01:   width_bits = CNT_W'(16);
      default: width_bits = CNT_W'(REG_W);
    endcase
  endfunction

  function automatic logic [REG_W-1:0] width_mask(input logic [1:0] w);
    case (w)
      2'b00:   width_mask = REG_W'(8'hFF);
      2'b01:   width_mask = REG_W'(16'hFFFF);
      default: width_mask = '1;
    endcase
  endfunction

  // Write data is left-aligned so the serializer always sends from the top bit.
  function automatic logic [REG_W-1:0] left_align(input logic [1:0] w,
                                                  input logic [REG_W-1:0] d);
    case (w)
      2'b00:   left_align = {d[7:0], {(REG_W-8){1'b0}}};
      2'b01:   left_align = {d[15:0], {(REG_W-16){1'b0}}};
      default: left_align = d;
    endcase
  endfunction

  // Last bit index (frame-global) of the current shifting segment and where it leads.
  always_comb begin
    n_bits   = width_bits(width_q);
    seg_end  = HDR_END;
    seg_next = S_HOLD;
    case (state_q)
      S_HDR: begin
        seg_end  = HDR_END;
        seg_next = rw_q ? S_WDATA : ((TURN_BITS > 0) ? S_TURN : S_RDATA);
      end
      S_TURN: begin
        seg_end  = TURN_END;
        seg_next = S_RDATA;
      end
      S_WDATA: seg_end = HDR_END + n_bits;
      S_RDATA: seg_end = TURN_END + n_bits;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rw_d     = rw_q;
    width_d  = width_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    div_wrap = (div_q == DIV_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          rw_d    = rw;
          width_d = txn_width;
          tx_d    = {txn_width, addr, rw ? left_align(txn_width, wdata) : {REG_W{1'b0}}};
          rx_d    = '0;
          cnt_d   = '0;
          div_d   = '0;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = rw;
        end
      end

      S_SETUP: begin
        div_d = div_wrap ? 8'd0 : div_q + 8'd1;
        if (div_wrap) state_d = S_HDR;
      end

      S_HDR, S_TURN, S_WDATA, S_RDATA: begin
        div_d = div_wrap ? 8'd0 : div_q + 8'd1;
        if (div_wrap) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // End of the high half: sample MISO, then present the next bit as SCK falls.
            sck_d  = 1'b0;
            if (state_q == S_RDATA) rx_d = {rx_q[REG_W-2:0], miso_s_q};
            mosi_d = tx_q[TX_W-1];
            tx_d   = {tx_q[TX_W-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == seg_end) state_d = seg_next;
          end
        end
      end

      S_HOLD: begin
        div_d = div_wrap ? 8'd0 : div_q + 8'd1;
        if (div_wrap) begin
          state_d = S_GAP;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          gap_d   = '0;
          if (!rw_q) rdata_d = rx_q & width_mask(width_q);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else gap_d = gap_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rw_q     <= 1'b0;
      width_q  <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      miso_m_q <= 1'b0;
      miso_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rw_q     <= rw_d;
      width_q  <= width_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      miso_m_q <= spi_miso;
      miso_s_q <= miso_m_q;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sck_q;
  assign spi_mosi  = mosi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_reg_host.sv
// Bench for spi_reg_host: two instances (CLK_DIV=4 and CLK_DIV=2) each talking to a
// behavioural SPI register slave with a small loopback register file.
module tb_spi_reg_host;

  localparam int AW      = 6;
  localparam int DW      = 32;
  localparam int TB_TURN = 8;
  localparam int TB_GAP  = 4;
  localparam int DIV0    = 4;
  localparam int DIV1    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    start_v;
  logic          rw;
  logic [1:0]    txn_width;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    busy_v, done_v, cs_n_v, sck_v, mosi_v;
  logic [1:0]    miso_v = '0;
  logic [DW-1:0] rdata_v [2];
  logic [2:0]    dbg_v [2];

  spi_reg_host #(.ADDR_W(AW), .REG_W(DW), .CLK_DIV(DIV0), .TURN_BITS(TB_TURN), .CS_GAP(TB_GAP)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .rw(rw), .txn_width(txn_width),
    .addr(addr), .wdata(wdata), .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]),
    .spi_cs_n(cs_n_v[0]), .spi_clk(sck_v[0]), .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0]),
    .dbg_state(dbg_v[0])
  );

  spi_reg_host #(.ADDR_W(AW), .REG_W(DW), .CLK_DIV(DIV1), .TURN_BITS(TB_TURN), .CS_GAP(TB_GAP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .rw(rw), .txn_width(txn_width),
    .addr(addr), .wdata(wdata), .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]),
    .spi_cs_n(cs_n_v[1]), .spi_clk(sck_v[1]), .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1]),
    .dbg_state(dbg_v[1])
  );

  // ---------------- slave model + bus monitors ----------------
  logic        prev_cs   [2] = '{1'b1, 1'b1};
  logic        prev_sck  [2] = '{1'b0, 1'b0};
  logic        prev_mosi [2] = '{1'b0, 1'b0};
  int          edges     [2] = '{0, 0};
  int          last_edges[2] = '{0, 0};
  logic [63:0] stream    [2];
  logic [63:0] last_stream [2];
  logic        f_rw      [2];
  int          f_n       [2] = '{8, 8};
  logic [5:0]  f_addr    [2];
  logic [31:0] tx_data   [2];
  int          frames    [2] = '{0, 0};
  int          gap_cnt   [2] = '{100, 100};
  int          last_gap  [2] = '{100, 100};
  int          last_rise [2] = '{-1, -1};
  int          viol      [2] = '{0, 0};
  int          per_bad   [2] = '{0, 0};
  int          dn_cnt    [2] = '{0, 0};
  logic [31:0] mem [2][64];
  int          cyc = 0;

  function automatic logic [31:0] mask_of(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  always @(negedge clk) begin : slave
    int dv;
    int k;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (cyc == 1) begin
        for (int a = 0; a < 64; a++) mem[g][a] = 32'h0;
        mem[g][6'h3F] = 32'hDEAD_BEEF;
        mem[g][6'h2A] = 32'hABCD_1234;
      end
      dv = (g == 0) ? DIV0 : DIV1;
      if (done_v[g]) dn_cnt[g]++;
      if (cs_n_v[g]) begin
        if (sck_v[g]) viol[g]++;
        if (!prev_cs[g]) begin
          frames[g]++;
          last_edges[g]  = edges[g];
          last_stream[g] = stream[g];
          if (f_rw[g] && edges[g] == 9 + f_n[g]) mem[g][f_addr[g]] = stream[g][31:0] & mask_of(f_n[g]);
          gap_cnt[g] = 0;
        end
        gap_cnt[g]++;
        miso_v[g] = 1'b0;
      end else begin
        if (prev_cs[g]) begin
          edges[g]     = 0;
          stream[g]    = '0;
          last_gap[g]  = gap_cnt[g];
          last_rise[g] = -1;
        end
        if (sck_v[g] && (mosi_v[g] != prev_mosi[g])) viol[g]++;
        if (sck_v[g] && !prev_sck[g]) begin
          edges[g]++;
          stream[g] = {stream[g][62:0], mosi_v[g]};
          if (last_rise[g] >= 0 && (cyc - last_rise[g]) != 2 * dv) per_bad[g]++;
          last_rise[g] = cyc;
          if (edges[g] == 9) begin
            f_rw[g]    = stream[g][8];
            f_n[g]     = (stream[g][7:6] == 2'b00) ? 8 : (stream[g][7:6] == 2'b01) ? 16 : 32;
            f_addr[g]  = stream[g][5:0];
            tx_data[g] = mem[g][stream[g][5:0]] & mask_of(f_n[g]);
          end
        end
        if (!sck_v[g] && prev_sck[g]) begin
          k = edges[g] - 9 - TB_TURN;
          if (!f_rw[g] && k >= 0 && k < f_n[g]) miso_v[g] = tx_data[g][f_n[g] - 1 - k];
        end
      end
      prev_cs[g]   = cs_n_v[g];
      prev_sck[g]  = sck_v[g];
      prev_mosi[g] = mosi_v[g];
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd_at_done [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [1:0] sel, input logic r, input logic [1:0] w,
                             input logic [5:0] a, input logic [31:0] d);
    rw = r; txn_width = w; addr = a; wdata = d;
    start_v = sel;
    @(negedge clk);
    start_v = 2'b00;
  endtask

  task automatic wait_idle(input logic [1:0] sel);
    int t;
    t = 0;
    rd_at_done[0] = 'x;
    rd_at_done[1] = 'x;
    while (((busy_v & sel) != 2'b00) && t < 3000) begin
      @(negedge clk);
      t++;
      for (int g = 0; g < 2; g++) if (done_v[g]) rd_at_done[g] = rdata_v[g];
    end
    check("idle_wait", busy_v & sel, 2'b00);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  w;
    logic [5:0]  a;
    logic [31:0] wd;
    int          exp_sck;
    logic [63:0] exp_stream;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  int   dn0 [2];
  int   fr0 [2];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vecs[0] = '{1'b1, 2'b00, 6'h15, 32'h1234_56A5, 17, 64'h0000_0000_0001_15A5, 32'h0000_0000};
    vecs[1] = '{1'b0, 2'b10, 6'h3F, 32'h0,         49, 64'h0000_BF00_0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 2'b01, 6'h2A, 32'h0,         33, 64'h0000_0000_6A00_0000, 32'h0000_1234};
    vecs[3] = '{1'b1, 2'b10, 6'h05, 32'h00C0_FFEE, 41, 64'h0000_0185_00C0_FFEE, 32'h0000_1234};
    vecs[4] = '{1'b0, 2'b10, 6'h05, 32'h0,         49, 64'h0000_8500_0000_0000, 32'h00C0_FFEE};
    vecs[5] = '{1'b1, 2'b01, 6'h00, 32'hFFFF_8001, 25, 64'h0000_0000_0140_8001, 32'h00C0_FFEE};
    vecs[6] = '{1'b0, 2'b00, 6'h00, 32'h0,         25, 64'h0000_0000_0000_0000, 32'h0000_0001};
    vecs[7] = '{1'b0, 2'b11, 6'h3F, 32'h0,         49, 64'h0000_FF00_0000_0000, 32'hDEAD_BEEF};

    rst_n = 1'b0; start_v = 2'b00; rw = 1'b0; txn_width = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n_v, 2'b11);
    check("rst_sck", sck_v, 2'b00);
    check("rst_mosi", mosi_v, 2'b00);
    check("rst_busy", busy_v, 2'b00);
    check("rst_done", done_v, 2'b00);
    check("rst_rdata0", rdata_v[0], 32'h0);
    check("rst_rdata1", rdata_v[1], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames on both instances in parallel.
    foreach (vecs[i]) begin
      for (int g = 0; g < 2; g++) begin dn0[g] = dn_cnt[g]; fr0[g] = frames[g]; end
      drive_start(2'b11, vecs[i].rw, vecs[i].w, vecs[i].a, vecs[i].wd);
      check($sformatf("v%0d_busy", i), busy_v, 2'b11);
      wait_idle(2'b11);
      for (int g = 0; g < 2; g++) begin
        check($sformatf("v%0d_d%0d_sck", i, g), last_edges[g], vecs[i].exp_sck);
        check($sformatf("v%0d_d%0d_mosi", i, g), last_stream[g], vecs[i].exp_stream);
        check($sformatf("v%0d_d%0d_rdata", i, g), rd_at_done[g], vecs[i].exp_rdata);
        check($sformatf("v%0d_d%0d_done", i, g), dn_cnt[g] - dn0[g], 1);
        check($sformatf("v%0d_d%0d_frame", i, g), frames[g] - fr0[g], 1);
      end
    end

    // Back-to-back on instance 0: start while busy is dropped, start in first IDLE cycle taken.
    dn0[0] = dn_cnt[0]; fr0[0] = frames[0];
    drive_start(2'b01, 1'b1, 2'b00, 6'h11, 32'h0000_003C);
    repeat (20) @(negedge clk);
    drive_start(2'b01, 1'b0, 2'b10, 6'h3F, 32'h0);
    wait_idle(2'b01);
    check("b2b_frames", frames[0] - fr0[0], 1);
    check("b2b_done", dn_cnt[0] - dn0[0], 1);
    check("b2b_first_mosi", last_stream[0], 64'h0001_113C);
    check("b2b_first_sck", last_edges[0], 17);
    drive_start(2'b01, 1'b0, 2'b00, 6'h11, 32'h0);
    check("b2b_third_busy", busy_v[0], 1'b1);
    wait_idle(2'b01);
    check("b2b_third_rdata", rd_at_done[0], 32'h0000_003C);
    check("b2b_third_mosi", last_stream[0], 64'h0011_0000);
    check("b2b_third_sck", last_edges[0], 25);
    check("b2b_gap_min", last_gap[0] >= TB_GAP, 1'b1);
    check("b2b_frames2", frames[0] - fr0[0], 2);

    // Reset in the middle of a write frame.
    drive_start(2'b11, 1'b1, 2'b10, 6'h05, 32'h1234_5678);
    begin
      int t;
      t = 0;
      while (edges[0] < 10 && t < 2000) begin @(negedge clk); t++; end
      check("rstmid_reach", edges[0] >= 10, 1'b1);
    end
    dn0[0] = dn_cnt[0]; dn0[1] = dn_cnt[1];
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_cs_n", cs_n_v, 2'b11);
    check("rstmid_busy", busy_v, 2'b00);
    check("rstmid_done", done_v, 2'b00);
    check("rstmid_rdata0", rdata_v[0], 32'h0);
    check("rstmid_rdata1", rdata_v[1], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rstmid_no_done0", dn_cnt[0] - dn0[0], 0);
    check("rstmid_no_done1", dn_cnt[1] - dn0[1], 0);

    // Aborted write must not reach the slave; loopback still returns the earlier value.
    drive_start(2'b11, 1'b0, 2'b10, 6'h05, 32'h0);
    wait_idle(2'b11);
    check("post_rst_rdata0", rd_at_done[0], 32'h00C0_FFEE);
    check("post_rst_rdata1", rd_at_done[1], 32'h00C0_FFEE);

    // Bus-level timing rules observed across the whole run.
    check("d0_mosi_stable", viol[0], 0);
    check("d1_mosi_stable", viol[1], 0);
    check("d0_sck_period", per_bad[0], 0);
    check("d1_sck_period", per_bad[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_host.md
Name: spi_reg_host

Overview:
- SPI mode-0 initiator that issues register read/write frames to the team's SPI register slave. The slave bridges those frames onto the 6-bit-address peripheral bus.
- Used as the bench/host-side driver and as the master in multi-chip harness builds.
- Converts a single-cycle command strobe into a complete chip-select-framed bit stream. On reads, returns the data shifted back on MISO.

Parameters:
- ADDR_W, 6: address field width in bits.
- REG_W, 32: maximum data width and rdata/wdata width.
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 2..255.
- TURN_BITS, 8: dummy SCK cycles between the address field and read data. The slave uses these to fetch.
- CS_GAP, 4: minimum clk cycles CS stays high between frames.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: command strobe. Accepted only when busy=0.
- rw, input, 1: 1 = write, 0 = read. Captured on an accepted start.
- txn_width, input, 2: data width. 00 = 8 bits, 01 = 16 bits, 10 or 11 = 32 bits. Captured on an accepted start.
- addr, input, ADDR_W: register address. Captured on an accepted start.
- wdata, input, REG_W: write data. Captured on an accepted start; the low bits of the selected width are sent.
- busy, output, 1: high from the cycle after an accepted start until the CS_GAP period ends.
- done, output, 1: one-cycle pulse when CS deasserts at frame end.
- rdata, output, REG_W: read result, zero-extended. Updated in the done cycle of read frames only; holds otherwise.
- spi_cs_n, output, 1: active-low chip select.
- spi_clk, output, 1: SCK; idles low.
- spi_mosi, output, 1: serial data to the slave, MSB first.
- spi_miso, input, 1: serial data from the slave. Double-flopped internally before use.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rdata=0.
  - State is IDLE and all counters are cleared.
  - Reset mid-frame aborts immediately: CS rises on the next edge and no done pulse is issued.
- Frame layout, MSB first on MOSI:
  - rw (1 bit), then txn_width (2 bits), then addr (ADDR_W bits).
  - Write: data follows, N bits where N is 8, 16 or 32.
  - Read: TURN_BITS dummy cycles with MOSI=0, then N bits sampled from MISO.
  - Total SCK cycles: 3+ADDR_W+N for writes; 3+ADDR_W+TURN_BITS+N for reads.
- SCK timing:
  - Each SCK cycle is CLK_DIV clk low, then CLK_DIV clk high.
  - MOSI changes only while SCK is low, at the start of the low half.
  - MISO is sampled, after the synchronizer, on the last clk of each high half.
- States and transitions:
  - IDLE: start && !busy goes to SETUP and latches all command fields.
  - SETUP: CS low, SCK low, MOSI = the first bit, for CLK_DIV cycles. Then go to HDR.
  - HDR: shift 3+ADDR_W bits. Go to WDATA if rw=1, else to TURN.
  - TURN: TURN_BITS SCK cycles, then go to RDATA.
  - WDATA / RDATA: shift N bits.
  - HOLD: SCK low, CS low, for CLK_DIV cycles. Then CS goes high, done pulses, and the state moves to GAP.
  - GAP: CS_GAP cycles with CS high, then IDLE with busy=0.
- start while busy: ignored, with no queuing and no error.
- start in the same cycle busy falls: this cannot happen, because busy is already 0 in IDLE. A start in the first IDLE cycle is accepted.
- rdata assembly: bits shift in MSB first into bit positions N-1..0; upper bits are forced to 0. Write frames leave rdata unchanged.
- Counters:
  - The bit counter is wide enough for 3+ADDR_W+TURN_BITS+REG_W.
  - The divider counter is 8 bits and wraps to 0 at CLK_DIV-1.

Test Plan:
- Reset mid-write:
  - Stimulus: start a write, then pulse rst_n=0 after 10 SCK cycles.
  - Response: CS high on the next clk, busy=0, no done pulse, rdata=0.
- 8-bit write:
  - Stimulus: rw=1, txn_width=00, addr=0x15, wdata=0xA5.
  - Response: 17 SCK cycles; MOSI stream 1,00,010101,10100101; done pulses once; rdata unchanged.
- 32-bit read:
  - Stimulus: rw=0, txn_width=10, addr=0x3F; slave model returns 0xDEADBEEF after 8 turn cycles.
  - Response: 49 SCK cycles; rdata=0xDEADBEEF at done.
- 16-bit read:
  - Stimulus: slave returns 0x1234 on a txn_width=01 read.
  - Response: rdata=0x00001234, upper 16 bits zero.
- Back-to-back starts:
  - Stimulus: a second start while busy, then a third start in the first IDLE cycle.
  - Response: the second start is ignored; the third is accepted; CS high is at least CS_GAP cycles between frames.
- Timing check with CLK_DIV=2:
  - Stimulus: run frames with CLK_DIV=2.
  - Response: SCK period 4 clk; MOSI never changes while SCK=1; the SPI register slave loopback round-trips wdata=0x00C0FFEE.
